// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// ----------------
// Serialises one SD command frame (start/transmit bits, 6-bit index,
// 32-bit argument, CRC7, end bit = 48 bits) onto mosi, MSB first. It then
// waits for the card's R1 response on miso and captures that byte.
// The CRC7 comes from an external crc_manager. This block clears that
// manager (crc_reset) and enables it (crc_en) while the 40 header/argument
// bits are on the line. The manager samples mosi on the falling edge, so
// crc8 is already final at the rising edge that ends the CMD phase.
//
// Ports
//   spi_clk    : single clock, rising-edge state updates
//   reset      : asynchronous, active-high reset
//   start      : command request, only honoured in IDLE
//   cmd_index  : 6-bit command index, captured on the start cycle
//   arg        : 32-bit command argument, captured on the start cycle
//   miso       : serial response from the card
//   crc8       : running CRC from crc_manager, CRC7 in bits [6:0]
//   mosi       : serial command stream (idles high)
//   crc_en     : CRC accumulate enable, high for the 40 header/argument bits
//   crc_reset  : CRC clear, high for the single CLR cycle
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   r1         : captured response byte, held until the next done
//   timeout    : response never started, valid with done
//
// Build option
//   SD_SEQ_RESP_TIMEOUT_EN : when defined, RESP_WAIT gives up after
//   RESP_WAIT_BITS cycles of miso=1. It then reports timeout=1 and
//   r1=8'hFF. When undefined, the block waits forever and timeout is
//   tied low.

module sd_cmd_sequencer #(
    parameter int RESP_WAIT_BITS = 128
) (
    input  logic        spi_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] arg,
    input  logic        miso,
    input  logic [7:0]  crc8,
    output logic        mosi,
    output logic        crc_en,
    output logic        crc_reset,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        CMD       = 3'd2,
        CRC       = 3'd3,
        STOP      = 3'd4,
        RESP_WAIT = 3'd5,
        RESP      = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Counter loads with (cycles in state - 1) and counts down to zero.
    localparam logic [7:0] RESP_WAIT_LOAD = 8'(RESP_WAIT_BITS - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [39:0] cmd_sr_q, cmd_sr_d;
    logic [6:0]  crc_sr_q, crc_sr_d;
    logic [6:0]  resp_sr_q, resp_sr_d;
    logic [7:0]  r1_q, r1_d;
    logic        mosi_q, mosi_d;
    logic        crc_en_q, crc_en_d;
    logic        crc_reset_q, crc_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef SD_SEQ_RESP_TIMEOUT_EN
    logic        timeout_q, timeout_d;
`endif

    // crc8[7] is not part of CRC7; this net only marks it as deliberately unused.
    logic unused_crc_msb_s;
    assign unused_crc_msb_s = crc8[7];

    // Next-state and next-output logic. The outputs are registered, so each
    // value computed here becomes visible in the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_sr_d    = cmd_sr_q;
        crc_sr_d    = crc_sr_q;
        resp_sr_d   = resp_sr_q;
        r1_d        = r1_q;
        mosi_d      = 1'b1;
        crc_en_d    = 1'b0;
        crc_reset_d = 1'b0;
        done_d      = 1'b0;
`ifdef SD_SEQ_RESP_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_sr_d    = {2'b01, cmd_index, arg};
                    crc_reset_d = 1'b1;
                    state_d     = CLR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR: begin
                // First header bit goes out as CMD is entered.
                mosi_d   = cmd_sr_q[39];
                cmd_sr_d = {cmd_sr_q[38:0], 1'b0};
                crc_en_d = 1'b1;
                cnt_d    = 8'd39;
                state_d  = CMD;
            end
            CMD: begin
                if (cnt_q == 8'd0) begin
                    // crc8 is final on this edge; latch it and start sending it.
                    mosi_d   = crc8[6];
                    crc_sr_d = {crc8[5:0], 1'b0};
                    cnt_d    = 8'd6;
                    state_d  = CRC;
                end else begin
                    mosi_d   = cmd_sr_q[39];
                    cmd_sr_d = {cmd_sr_q[38:0], 1'b0};
                    crc_en_d = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                end
            end
            CRC: begin
                if (cnt_q == 8'd0) begin
                    state_d = STOP;
                end else begin
                    mosi_d   = crc_sr_q[6];
                    crc_sr_d = {crc_sr_q[5:0], 1'b0};
                    cnt_d    = cnt_q - 8'd1;
                end
            end
            STOP: begin
                cnt_d   = RESP_WAIT_LOAD;
                state_d = RESP_WAIT;
            end
            RESP_WAIT: begin
                if (!miso) begin
                    // This low bit is r1[7]; the shifter starts from zero.
                    resp_sr_d = 7'd0;
                    cnt_d     = 8'd6;
                    state_d   = RESP;
                end else begin
`ifdef SD_SEQ_RESP_TIMEOUT_EN
                    if (cnt_q == 8'd0) begin
                        r1_d      = 8'hFF;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
`else
                    state_d = RESP_WAIT;
`endif
                end
            end
            RESP: begin
                if (cnt_q == 8'd0) begin
                    r1_d    = {resp_sr_q, miso};
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SD_SEQ_RESP_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end else begin
                    resp_sr_d = {resp_sr_q[5:0], miso};
                    cnt_d     = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame without a done pulse.
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            cmd_sr_q    <= 40'd0;
            crc_sr_q    <= 7'd0;
            resp_sr_q   <= 7'd0;
            r1_q        <= 8'hFF;
            mosi_q      <= 1'b1;
            crc_en_q    <= 1'b0;
            crc_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SD_SEQ_RESP_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            crc_sr_q    <= crc_sr_d;
            resp_sr_q   <= resp_sr_d;
            r1_q        <= r1_d;
            mosi_q      <= mosi_d;
            crc_en_q    <= crc_en_d;
            crc_reset_q <= crc_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SD_SEQ_RESP_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign mosi      = mosi_q;
    assign crc_en    = crc_en_q;
    assign crc_reset = crc_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign r1        = r1_q;
`ifdef SD_SEQ_RESP_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed, table-driven bench for sd_cmd_sequencer. A bit-serial CRC7
// model stands in for crc_manager (falling-edge sampling of mosi). Every
// expected frame and response in the table is a hand-written constant.

module tb_sd_cmd_sequencer;

    logic        spi_clk;
    logic        reset;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] arg;
    logic        miso;
    logic [7:0]  crc8;
    logic        mosi;
    logic        crc_en;
    logic        crc_reset;
    logic        busy;
    logic        done;
    logic [7:0]  r1;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    sd_cmd_sequencer #(.RESP_WAIT_BITS(128)) dut (
        .spi_clk   (spi_clk),
        .reset     (reset),
        .start     (start),
        .cmd_index (cmd_index),
        .arg       (arg),
        .miso      (miso),
        .crc8      (crc8),
        .mosi      (mosi),
        .crc_en    (crc_en),
        .crc_reset (crc_reset),
        .busy      (busy),
        .done      (done),
        .r1        (r1),
        .timeout   (timeout)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    // Stand-in crc_manager: CRC7 (x^7 + x^3 + 1), mosi sampled on falling edge.
    logic [6:0] crc_m;
    always @(negedge spi_clk or posedge reset) begin
        if (reset)
            crc_m <= 7'd0;
        else if (crc_reset)
            crc_m <= 7'd0;
        else if (crc_en)
            crc_m <= {crc_m[5:0], 1'b0} ^ (((crc_m[6] ^ mosi) == 1'b1) ? 7'h09 : 7'h00);
    end
    assign crc8 = {1'b0, crc_m};

    // Count done pulses so that spurious or missing pulses are visible.
    always @(posedge spi_clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] frame;
        int          idle;
        logic [7:0]  resp;
        bit          poke;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue start and capture the 48-bit frame; optionally poke start mid-frame.
    task automatic send_frame(input vec_t v);
        logic [47:0] fr;
        logic [47:0] en;
        @(posedge spi_clk); #1;
        start = 1'b1; cmd_index = v.idx; arg = v.arg;
        @(posedge spi_clk); #1;
        start = 1'b0; cmd_index = 6'($urandom); arg = $urandom;
        @(negedge spi_clk);
        check("clr_state", {61'd0, crc_reset, mosi, busy}, 64'h7);
        for (int i = 0; i < 48; i++) begin
            @(posedge spi_clk);
            if (v.poke && i == 10) begin
                #1; start = 1'b1; cmd_index = 6'd55; arg = 32'hFFFF_FFFF;
            end
            if (v.poke && i == 12) begin
                #1; start = 1'b0;
            end
            @(negedge spi_clk);
            fr[47-i] = mosi;
            en[47-i] = crc_en;
        end
        check("frame", {16'd0, fr}, {16'd0, v.frame});
        check("crc_en_window", {16'd0, en}, {16'd0, 40'hFF_FFFF_FFFF, 8'h00});
    endtask

    task automatic run_cmd(input vec_t v);
        int  d0;
        int  stray;
        logic b;
        d0 = done_cnt;
        send_frame(v);
        for (int j = 0; j < v.idle + 8; j++) begin
            @(posedge spi_clk); #1;
            if (j < v.idle) b = 1'b1;
            else            b = v.resp[7 - (j - v.idle)];
            miso = b;
        end
        @(posedge spi_clk); #1;
        miso = 1'b1;
        @(negedge spi_clk);
        check("done_pulse", {56'd0, done, busy, timeout, 5'd0}, {56'd0, 1'b1, 1'b1, 1'b0, 5'd0});
        check("r1_at_done", {56'd0, r1}, {56'd0, v.resp});
        @(posedge spi_clk);
        @(negedge spi_clk);
        check("after_done", {62'd0, done, busy}, 64'd0);
        check("r1_hold", {56'd0, r1}, {56'd0, v.resp});
        check("done_count", 64'(done_cnt - d0), 64'd1);
        if (v.poke) begin
            stray = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge spi_clk);
                if (busy || !mosi) stray++;
            end
            check("no_queued_frame", 64'(stray), 64'd0);
        end
    endtask

    initial begin
        int d0;
        int cyc;
        bit seen;
        vecs[0] = '{6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 0, 8'h01, 1'b0};
        vecs[1] = '{6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, 2, 8'h01, 1'b0};
        vecs[2] = '{6'd17, 32'h0000_0000, 48'h51_0000_0000_55, 5, 8'h00, 1'b1};
        vecs[3] = '{6'd55, 32'h0000_0000, 48'h77_0000_0000_65, 1, 8'h25, 1'b0};
        vecs[4] = '{6'd41, 32'h4000_0000, 48'h69_4000_0000_77, 3, 8'h7E, 1'b0};

        reset = 1'b1; start = 1'b0; cmd_index = 6'd0; arg = 32'd0; miso = 1'b1;
        #12;
        check("reset_values", {50'd0, mosi, crc_en, crc_reset, busy, done, r1, timeout},
              {50'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0});
        @(negedge spi_clk); reset = 1'b0;
        repeat (2) @(posedge spi_clk);
        @(negedge spi_clk);
        check("idle_outputs", {61'd0, mosi, crc_en, crc_reset}, 64'h4);

        for (int t = 0; t < 5; t++) run_cmd(vecs[t]);

        // Reset in the middle of CMD (bit 20) aborts silently.
        d0 = done_cnt;
        @(posedge spi_clk); #1;
        start = 1'b1; cmd_index = 6'd0; arg = 32'd0;
        @(posedge spi_clk); #1;
        start = 1'b0;
        repeat (21) @(posedge spi_clk);
        @(negedge spi_clk);
        check("mid_frame_busy", {62'd0, busy, crc_en}, 64'h3);
        #2; reset = 1'b1; #1;
        check("async_reset_values", {50'd0, mosi, crc_en, crc_reset, busy, done, r1, timeout},
              {50'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0});
        @(negedge spi_clk); reset = 1'b0;
        repeat (60) @(posedge spi_clk);
        @(negedge spi_clk);
        check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        check("idle_after_abort", {62'd0, busy, mosi}, 64'h1);
        run_cmd(vecs[0]);

        // Response never arrives.
        d0 = done_cnt;
        send_frame(vecs[1]);
        miso = 1'b1;
        seen = 1'b0;
        cyc = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge spi_clk);
            @(negedge spi_clk);
            if (done) seen = 1'b1;
            else      cyc++;
        end
`ifdef SD_SEQ_RESP_TIMEOUT_EN
        check("timeout_seen", {63'd0, seen}, 64'd1);
        check("timeout_latency", 64'(cyc), 64'd128);
        check("timeout_flags", {55'd0, timeout, r1}, {55'd0, 1'b1, 8'hFF});
        @(posedge spi_clk);
        @(negedge spi_clk);
        check("timeout_hold", {54'd0, busy, timeout, r1}, {54'd0, 1'b0, 1'b1, 8'hFF});
`else
        check("wait_forever_no_done", {63'd0, seen}, 64'd0);
        check("wait_forever_busy", {62'd0, busy, timeout}, 64'h2);
        check("wait_forever_r1", {56'd0, r1}, {56'd0, 8'h01});
        @(negedge spi_clk); reset = 1'b1;
        @(negedge spi_clk); reset = 1'b0;
        check("recover_reset", {54'd0, busy, timeout, r1}, {54'd0, 1'b0, 1'b0, 8'hFF});
`endif
        run_cmd(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter RESP_WAIT_BITS, default 128, giving the maximum number of spi_clk cycles spent waiting for a response start bit.
REQ-002 The block SHALL have port spi_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: command request, sampled only in IDLE.
REQ-005 The block SHALL have port cmd_index, input, 6 bits: SD command index.
REQ-006 The block SHALL have port arg, input, 32 bits: command argument.
REQ-007 The block SHALL have port miso, input, 1 bit: serial response from the card.
REQ-008 The block SHALL have port crc8, input, 8 bits: running CRC from crc_manager; bits [6:0] hold CRC7.
REQ-009 The block SHALL have port mosi, output, 1 bit: serial command stream, MSB first.
REQ-010 The block SHALL have port crc_en, output, 1 bit: enable to crc_manager.
REQ-011 The block SHALL have port crc_reset, output, 1 bit: clear to crc_manager.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port r1, output, 8 bits: captured response byte.
REQ-015 The block SHALL have port timeout, output, 1 bit: no response was found; valid with done.

Function
REQ-016 The states SHALL be IDLE, CLR, CMD, CRC, STOP, RESP_WAIT, RESP, DONE.
REQ-017 In IDLE, start=1 SHALL latch {2'b01, cmd_index, arg} into a 40-bit shift register and go to CLR.
REQ-018 CLR SHALL last 1 cycle with crc_reset=1 and mosi=1.
REQ-019 CMD SHALL last 40 cycles, present shift-register bits MSB first on mosi, and hold crc_en=1 coincident with those bits.
REQ-020 crc_manager is required to sample mosi on the falling edge of spi_clk, so crc8 is complete at the rising edge that ends CMD.
REQ-021 On the CMD-to-CRC edge, the block SHALL latch crc8[6:0]; CRC SHALL then last 7 cycles, sending the latched value MSB first with crc_en=0.
REQ-022 STOP SHALL last 1 cycle with mosi=1 (end bit), giving a 48-bit frame.
REQ-023 In RESP_WAIT, mosi SHALL be 1 and miso SHALL be sampled each cycle.
REQ-024 In RESP_WAIT, miso=0 SHALL count as r1 bit 7 and go to RESP.
REQ-025 RESP SHALL shift in the remaining 7 bits, MSB first, then go to DONE.
REQ-026 DONE SHALL last 1 cycle: done=1, r1 updated, timeout updated, then return to IDLE.
REQ-027 r1 and timeout SHALL hold their values until the next DONE.
REQ-028 In IDLE, mosi SHALL be 1, crc_en SHALL be 0, and crc_reset SHALL be 0.
REQ-029 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-030 cmd_index and arg SHALL be don't-care after the start cycle.
REQ-031 Latency from start to the first command bit SHALL be 2 rising edges (IDLE to CLR, CLR to CMD).
REQ-032 The bit counter SHALL be 8 bits wide and reload on each state entry; no wrap-around within a state is permitted.

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE and the following output values: mosi=1, crc_en=0, crc_reset=0, busy=0, done=0, r1=8'hFF, timeout=0.
REQ-034 reset asserted mid-frame or mid-response SHALL abort without a done pulse.
REQ-035 After reset deasserts, the next start SHALL begin a fresh CLR.

Configuration
REQ-036 With SD_SEQ_RESP_TIMEOUT_EN defined, RESP_WAIT exceeding RESP_WAIT_BITS cycles with miso=1 SHALL go to DONE with timeout=1 and r1=8'hFF.
REQ-037 Without SD_SEQ_RESP_TIMEOUT_EN, RESP_WAIT SHALL wait indefinitely, timeout SHALL be tied to 0, and RESP_WAIT_BITS SHALL be unused.

Verification
REQ-038 CMD0 test: start with cmd_index=0, arg=0, with a golden CRC model -> mosi frame 40 00 00 00 00 95, then miso byte 0x01 -> done with r1=8'h01, timeout=0.
REQ-039 CMD8 test: start with cmd_index=8, arg=32'h000001AA -> frame 48 00 00 01 AA 87, with crc_en high for exactly 40 cycles.
REQ-040 CMD17 test: start with cmd_index=17, arg=0 -> frame 51 00 00 00 00 55; miso idles high for 5 cycles, then sends 0x00 -> r1=8'h00.
REQ-041 Timeout test: with SD_SEQ_RESP_TIMEOUT_EN defined, miso held at 1 -> done occurs 128 cycles after STOP with timeout=1 and r1=8'hFF.
REQ-042 Reset test: reset pulsed at CMD bit 20 -> all outputs return to reset values immediately, with no done pulse; a following CMD0 produces a correct frame.
REQ-043 Busy test: start re-asserted while busy=1 -> ignored, and only one frame appears on mosi.
